// File: rtl/adc_ascii_pkg.sv
// rtl/adc_ascii_pkg.sv - shared states and ASCII constants for the ADC-to-UART framer.
// Option ADC_ASCII_HEX_EN (hex frames) is selected in adc_ascii_framer.sv.
package adc_ascii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    localparam logic [7:0] CHR_0  = 8'h30;
    localparam logic [7:0] CHR_A  = 8'h41;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;

    localparam int MAX_FRAME = 5;

    function automatic logic [7:0] hex_char(input logic [3:0] d);
        return (d < 4'd10) ? CHR_0 + {4'd0, d} : CHR_A + {4'd0, d} - 8'd10;
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// rtl/bin2bcd8.sv - sequential double-dabble, 8-bit binary to three BCD digits in 8 cycles.
module bin2bcd8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // v[19:8] holds the BCD digits, v[7:0] the binary bits still to shift in
    logic [19:0] v;
    logic [2:0]  cnt;
    logic        run;

    function automatic logic [19:0] dabble(input logic [19:0] x);
        logic [19:0] y;
        y = x;
        for (int i = 0; i < 3; i++) begin
            if (y[8+4*i +: 4] >= 4'd5)
                y[8+4*i +: 4] = y[8+4*i +: 4] + 4'd3;
        end
        return {y[18:0], 1'b0};
    endfunction

    // The start edge performs the first iteration, so seven more follow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                v   <= dabble({12'd0, bin});
                cnt <= 3'd1;
                run <= 1'b1;
            end else if (run) begin
                v   <= dabble(v);
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign hund = v[19:16];
    assign tens = v[15:12];
    assign ones = v[11:8];

endmodule

// File: rtl/adc_ascii_framer.sv
// rtl/adc_ascii_framer.sv - frames ADC samples as ASCII digits plus EOL for a UART TX.
// Define ADC_ASCII_HEX_EN for two-digit uppercase hex frames instead of decimal.
module adc_ascii_framer
    import adc_ascii_pkg::*;
#(
    parameter int EOL_CRLF      = 1,
    parameter int LEADING_ZEROS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       sample_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       frame_busy,
    output logic [7:0] drop_cnt
);

    state_t                      state;
    logic [MAX_FRAME-1:0][7:0]   frame_q;
    logic [MAX_FRAME-1:0][7:0]   frame_d;
    logic [2:0]                  len_q;
    logic [2:0]                  len_d;
    logic [2:0]                  idx;
    logic                        accept;

    assign accept       = (state == IDLE) && sample_valid;
    assign sample_ready = (state == IDLE);
    assign frame_busy   = (state != IDLE);

`ifdef ADC_ASCII_HEX_EN
    logic [7:0] sample_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sample_q <= '0;
        else if (accept)
            sample_q <= sample;
    end
`else
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       bcd_done;

    bin2bcd8 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (sample),
        .done  (bcd_done),
        .hund  (hund),
        .tens  (tens),
        .ones  (ones)
    );
`endif

    // Packs the frame left-justified; len_d doubles as the write pointer
    always_comb begin
        frame_d = '0;
        len_d   = '0;
`ifdef ADC_ASCII_HEX_EN
        frame_d[0] = hex_char(sample_q[7:4]);
        frame_d[1] = hex_char(sample_q[3:0]);
        len_d      = 3'd2;
`else
        if (LEADING_ZEROS != 0 || hund != 4'd0) begin
            frame_d[len_d] = CHR_0 + {4'd0, hund};
            len_d          = len_d + 3'd1;
        end
        if (LEADING_ZEROS != 0 || hund != 4'd0 || tens != 4'd0) begin
            frame_d[len_d] = CHR_0 + {4'd0, tens};
            len_d          = len_d + 3'd1;
        end
        frame_d[len_d] = CHR_0 + {4'd0, ones};
        len_d          = len_d + 3'd1;
`endif
        if (EOL_CRLF != 0) begin
            frame_d[len_d] = CHR_CR;
            len_d          = len_d + 3'd1;
        end
        frame_d[len_d] = CHR_LF;
        len_d          = len_d + 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            drop_cnt <= 8'h00;
            idx      <= '0;
            len_q    <= '0;
            frame_q  <= '0;
        end else begin
            tx_start <= 1'b0;
            if (sample_valid && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (sample_valid)
`ifdef ADC_ASCII_HEX_EN
                        state <= LOAD;
`else
                        state <= CONVERT;
`endif
                end
`ifndef ADC_ASCII_HEX_EN
                CONVERT: if (bcd_done) state <= LOAD;
`endif
                LOAD: begin
                    frame_q <= frame_d;
                    len_q   <= len_d;
                    idx     <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= frame_q[idx];
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: if (tx_busy) state <= WAIT_LO;
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx == len_q - 3'd1) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
